// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq
// Steps a frame index through N_FRAMES consecutive sprite ids. One step is
// taken for every HOLD accepted animation ticks. Modes are loop, ping-pong,
// one-shot and freeze. A tick is any level change of the slow animation
// clock, seen through a two-flop stage.
//
// Ports:
//   clk            system clock
//   rstn           synchronous active-low reset
//   clk_flash_anim slow animation clock; each level change is one tick
//   en             1 = ticks are accepted, 0 = sequence frozen
//   mode           00 loop, 01 ping-pong, 10 one-shot, 11 freeze
//   restart        single-cycle pulse; returns the sequence to frame 0
//   id             current sprite id (NULL_ID once a one-shot has finished)
//   frame          current frame index
//   busy           1 while the sequence has not finished
//   done           one-cycle pulse when a one-shot completes
//
// Handshake: there is no valid/ready pair. The outputs are always valid.
// A tick changes frame and id one clock after the input change is captured.
// restart and rstn act at the clock edge where they are sampled.
module sprite_anim_seq #(
  parameter int ID_W     = 6,
  parameter int BASE_ID  = 4,
  parameter int N_FRAMES = 4,
  parameter int HOLD     = 1,
  parameter int NULL_ID  = 63,
  localparam int FW      = (N_FRAMES > 2) ? $clog2(N_FRAMES) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clk_flash_anim,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic            restart,
  output logic [ID_W-1:0] id,
  output logic [FW-1:0]   frame,
  output logic            busy,
  output logic            done
);

  if (BASE_ID + N_FRAMES - 1 >= NULL_ID || NULL_ID > (1 << ID_W) - 1) begin : g_bad_ids
    $error("sprite_anim_seq: sprite id range overlaps NULL_ID or NULL_ID does not fit in ID_W");
  end
  if (N_FRAMES < 2 || N_FRAMES > 64) begin : g_bad_frames
    $error("sprite_anim_seq: N_FRAMES must be in 2..64");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("sprite_anim_seq: HOLD must be in 1..255");
  end

  typedef enum logic { RUN = 1'b0, FINISHED = 1'b1 } state_t;

  localparam logic [FW-1:0] LAST      = FW'(N_FRAMES - 1);
  localparam logic [FW-1:0] ONE       = FW'(1);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);
  localparam logic          UP        = 1'b0;
  localparam logic          DOWN      = 1'b1;

  state_t        state;
  logic          s1;
  logic          s2;
  logic [FW-1:0] f;
  logic [7:0]    hold_cnt;
  logic          dir;
  logic          tick;
  logic          accept;

  // Both edges of the animation clock count as ticks.
  assign tick   = s1 ^ s2;
  assign accept = tick & en & (state == RUN) & (mode != 2'b11);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // Load the current input into both flops so that reset never
      // produces a tick.
      s1       <= clk_flash_anim;
      s2       <= clk_flash_anim;
      f        <= '0;
      hold_cnt <= '0;
      dir      <= UP;
      state    <= RUN;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      s1   <= clk_flash_anim;
      s2   <= s1;
      done <= 1'b0;
      if (restart) begin
        // Restart has priority. A tick in the same cycle is dropped.
        f        <= '0;
        hold_cnt <= '0;
        dir      <= UP;
        state    <= RUN;
        busy     <= 1'b1;
      end else if (accept) begin
        if (hold_cnt < HOLD_LAST) begin
          hold_cnt <= hold_cnt + 8'd1;
        end else begin
          hold_cnt <= '0;
          case (mode)
            2'b00: begin
              dir <= UP;
              f   <= (f == LAST) ? '0 : f + ONE;
            end
            2'b01: begin
              // Turn around without repeating the end frame.
              if (dir == UP) begin
                if (f == LAST) begin
                  dir <= DOWN;
                  f   <= LAST - ONE;
                end else begin
                  f <= f + ONE;
                end
              end else begin
                if (f == '0) begin
                  dir <= UP;
                  f   <= ONE;
                end else begin
                  f <= f - ONE;
                end
              end
            end
            2'b10: begin
              if (f < LAST) begin
                f <= f + ONE;
              end else begin
                state <= FINISHED;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    id    = (state == FINISHED) ? ID_W'(NULL_ID) : ID_W'(BASE_ID) + ID_W'(f);
    frame = f;
  end

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Testbench for sprite_anim_seq. It uses two instances. Instance a has the
// default parameters and covers loop, ping-pong, en/freeze gaps, restart
// and reset. Instance b has HOLD=2 and covers one-shot completion and the
// hold count. The driver pushes each expected output word and the cycle at
// which it is due. The monitor pops and compares on the falling edge.
module tb_sprite_anim_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flash_a, en_a, restart_a;
  logic [1:0] mode_a;
  logic       flash_b, en_b, restart_b;
  logic [1:0] mode_b;
  logic [5:0] id_a, id_b;
  logic [1:0] frame_a, frame_b;
  logic       busy_a, busy_b, done_a, done_b;

  sprite_anim_seq u_a (
    .clk(clk), .rstn(rstn), .clk_flash_anim(flash_a), .en(en_a), .mode(mode_a),
    .restart(restart_a), .id(id_a), .frame(frame_a), .busy(busy_a), .done(done_a)
  );

  sprite_anim_seq #(.HOLD(2)) u_b (
    .clk(clk), .rstn(rstn), .clk_flash_anim(flash_b), .en(en_b), .mode(mode_b),
    .restart(restart_b), .id(id_b), .frame(frame_b), .busy(busy_b), .done(done_b)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard. The expected word is {sel, done, busy, frame[1:0], id[5:0]}.
  logic [10:0] exp_q[$];
  int          due_q[$];
  string       name_q[$];
  int          tests_run = 0;
  int          failed = 0;

  logic [10:0] m_exp, m_act;
  int          m_due;
  string       m_name;

  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      m_exp  = exp_q.pop_front();
      m_due  = due_q.pop_front();
      m_name = name_q.pop_front();
      m_act  = m_exp[10] ? {1'b1, done_b, busy_b, frame_b, id_b}
                         : {1'b0, done_a, busy_a, frame_a, id_a};
      tests_run++;
      if (m_act != m_exp || m_due != cyc) begin
        failed++;
        $display("FAIL %s cycle %0d (due %0d): got id=%0d frame=%0d busy=%0b done=%0b, want id=%0d frame=%0d busy=%0b done=%0b",
                 m_name, cyc, m_due, m_act[5:0], m_act[7:6], m_act[8], m_act[9],
                 m_exp[5:0], m_exp[7:6], m_exp[8], m_exp[9]);
      end
    end
  end

  // Instance a never runs one-shot, so done_a must never be asserted.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      failed++;
      $display("FAIL done_a_never cycle %0d: done asserted on instance a", cyc);
    end
  end

  // Driver tasks. The driver always acts 1 time unit after a rising edge.
  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic dn, input logic bsy,
                      input logic [1:0] fr, input logic [5:0] idv,
                      input int lat, input string nm);
    exp_q.push_back({sel, dn, bsy, fr, idv});
    due_q.push_back(cyc + lat);
    name_q.push_back(nm);
  endtask

  // One level change. The new id is due two edges later.
  task automatic tick(input logic sel, input logic [5:0] idv, input logic [1:0] fr,
                      input logic bsy, input string nm);
    if (sel) flash_b = ~flash_b;
    else     flash_a = ~flash_a;
    push(sel, 1'b0, bsy, fr, idv, 2, nm);
    cyc_wait(4);
  endtask

  task automatic do_restart(input logic sel, input string nm);
    if (sel) restart_b = 1'b1;
    else     restart_a = 1'b1;
    push(sel, 1'b0, 1'b1, 2'd0, 6'd4, 1, nm);
    cyc_wait(1);
    restart_a = 1'b0;
    restart_b = 1'b0;
    cyc_wait(3);
  endtask

  logic [5:0] loop_exp [8] = '{6'd6, 6'd7, 6'd4, 6'd5, 6'd6, 6'd7, 6'd4, 6'd5};
  logic [5:0] pp_exp   [8] = '{6'd5, 6'd6, 6'd7, 6'd6, 6'd5, 6'd4, 6'd5, 6'd6};
  logic [5:0] os_exp   [7] = '{6'd4, 6'd5, 6'd5, 6'd6, 6'd6, 6'd7, 6'd7};
  logic [1:0] os_fr    [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

  initial begin
    rstn = 1'b0;
    flash_a = 1'b0; en_a = 1'b1; mode_a = 2'b00; restart_a = 1'b0;
    flash_b = 1'b0; en_b = 1'b1; mode_b = 2'b10; restart_b = 1'b0;
    cyc_wait(2);
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 0, "reset_a");
    push(1'b1, 1'b0, 1'b1, 2'd0, 6'd4, 0, "reset_b");
    cyc_wait(1);
    rstn = 1'b1;
    cyc_wait(2);

    tests_run++;
    if (id_a !== 6'd4 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      failed++;
      $display("FAIL post_reset_a: id=%0d busy=%0b done=%0b", id_a, busy_a, done_a);
    end
    tests_run++;
    if (id_b !== 6'd4 || busy_b !== 1'b1 || done_b !== 1'b0) begin
      failed++;
      $display("FAIL post_reset_b: id=%0d busy=%0b done=%0b", id_b, busy_b, done_b);
    end

    // Loop: the id must not move one edge after capture, but must move after two.
    flash_a = ~flash_a;
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 1, "loop_lat1");
    push(1'b0, 1'b0, 1'b1, 2'd1, 6'd5, 2, "loop_t1");
    cyc_wait(4);
    for (int i = 0; i < 8; i++) tick(1'b0, loop_exp[i], loop_exp[i][1:0], 1'b1, "loop");

    // Ping-pong with no repeated end frames.
    mode_a = 2'b01;
    do_restart(1'b0, "pp_restart");
    for (int i = 0; i < 8; i++) tick(1'b0, pp_exp[i], pp_exp[i][1:0], 1'b1, "pingpong");

    // en=0 gap, then freeze-mode gap.
    mode_a = 2'b00;
    do_restart(1'b0, "gap_restart");
    tick(1'b0, 6'd5, 2'd1, 1'b1, "gap_start");
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 6'd5, 2'd1, 1'b1, "en_gap");
    en_a = 1'b1;
    tick(1'b0, 6'd6, 2'd2, 1'b1, "en_resume");
    mode_a = 2'b11;
    for (int i = 0; i < 3; i++) tick(1'b0, 6'd6, 2'd2, 1'b1, "freeze_gap");
    mode_a = 2'b00;
    tick(1'b0, 6'd7, 2'd3, 1'b1, "freeze_resume");

    // Ping-pong going down, then loop continues upward from the current frame.
    mode_a = 2'b01;
    do_restart(1'b0, "mc_restart");
    tick(1'b0, 6'd5, 2'd1, 1'b1, "mc_pp");
    tick(1'b0, 6'd6, 2'd2, 1'b1, "mc_pp");
    tick(1'b0, 6'd7, 2'd3, 1'b1, "mc_pp");
    tick(1'b0, 6'd6, 2'd2, 1'b1, "mc_pp_down");
    mode_a = 2'b00;
    tick(1'b0, 6'd7, 2'd3, 1'b1, "mc_loop_up");
    tick(1'b0, 6'd4, 2'd0, 1'b1, "mc_loop_wrap");

    // The restart lands in the same cycle as a pending tick at id 6.
    do_restart(1'b0, "rt_restart");
    tick(1'b0, 6'd5, 2'd1, 1'b1, "rt_pre");
    tick(1'b0, 6'd6, 2'd2, 1'b1, "rt_pre");
    flash_a = ~flash_a;
    cyc_wait(1);
    restart_a = 1'b1;
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 1, "rt_same_cycle");
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 2, "rt_tick_dropped");
    cyc_wait(1);
    restart_a = 1'b0;
    cyc_wait(3);
    tick(1'b0, 6'd5, 2'd1, 1'b1, "rt_next");

    // Reset while the input is high, then the input is held at 1.
    rstn = 1'b0;
    flash_a = 1'b1;
    cyc_wait(2);
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 0, "rst_high");
    rstn = 1'b1;
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 2, "rst_no_tick");
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 5, "rst_no_tick_late");
    cyc_wait(6);

    // Reset pulsed mid-run at id 7.
    tick(1'b0, 6'd5, 2'd1, 1'b1, "rst_run");
    tick(1'b0, 6'd6, 2'd2, 1'b1, "rst_run");
    tick(1'b0, 6'd7, 2'd3, 1'b1, "rst_run");
    rstn = 1'b0;
    push(1'b0, 1'b0, 1'b1, 2'd0, 6'd4, 1, "rst_midrun");
    cyc_wait(1);
    rstn = 1'b1;
    cyc_wait(3);

    // One-shot with HOLD=2 on instance b.
    for (int i = 0; i < 7; i++) tick(1'b1, os_exp[i], os_fr[i], 1'b1, "oneshot");
    flash_b = ~flash_b;
    push(1'b1, 1'b0, 1'b1, 2'd3, 6'd7, 1, "os_before_done");
    push(1'b1, 1'b1, 1'b0, 2'd3, 6'd63, 2, "os_done_pulse");
    push(1'b1, 1'b0, 1'b0, 2'd3, 6'd63, 3, "os_done_one_cycle");
    cyc_wait(4);
    tick(1'b1, 6'd63, 2'd3, 1'b0, "os_extra");
    tick(1'b1, 6'd63, 2'd3, 1'b0, "os_extra");
    mode_b = 2'b00;
    tick(1'b1, 6'd63, 2'd3, 1'b0, "os_mode_ignored");
    mode_b = 2'b10;
    do_restart(1'b1, "os_restart");
    tick(1'b1, 6'd4, 2'd0, 1'b1, "os_hold");
    tick(1'b1, 6'd5, 2'd1, 1'b1, "os_hold");
    tick(1'b1, 6'd5, 2'd1, 1'b1, "os_hold");
    en_b = 1'b0;
    tick(1'b1, 6'd5, 2'd1, 1'b1, "os_en_gap");
    tick(1'b1, 6'd5, 2'd1, 1'b1, "os_en_gap");
    en_b = 1'b1;
    tick(1'b1, 6'd6, 2'd2, 1'b1, "os_hold_resume");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc_wait(1);
    while (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      void'(due_q.pop_front());
      m_name = name_q.pop_front();
      tests_run++;
      failed++;
      $display("FAIL %s: never checked, want word %h", m_name, m_exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/sprite_anim_seq.md
Name: sprite_anim_seq

Overview:
Parametrised sprite-frame sequencer for animated tiles such as coins, blocks and flames. It counts level changes on the slow flash-animation clock and steps a frame index through N_FRAMES consecutive sprite ids. It supports loop, ping-pong, one-shot and freeze modes, a per-frame hold count, enable and restart. Its output id feeds the sprite ROM address mux in the renderer.

Parameters:
ID_W, 6, width of sprite id output
BASE_ID, 4, sprite id of frame 0
N_FRAMES, 4, frame count, legal range 2..64
HOLD, 1, animation ticks per frame, legal range 1..255
NULL_ID, 63, id output when a one-shot has finished (blank sprite)
Elaboration error if BASE_ID+N_FRAMES-1 >= NULL_ID or NULL_ID > 2^ID_W-1.

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock; reset is synchronous and active-low
clk_flash_anim  in  1  slow animation clock from the clock divider; every level change is one tick
en  in  1  1 = ticks are accepted; 0 = state frozen
mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 freeze
restart  in  1  single-cycle pulse; returns the sequence to frame 0
id  out  ID_W  current sprite id
frame  out  clog2(N_FRAMES), min 1  current frame index
busy  out  1  1 while not FINISHED
done  out  1  one-cycle pulse when a one-shot completes

Behaviour:
- Tick detection: clk_flash_anim passes through a 2-flop stage s1→s2. tick = (s1 != s2).
- Latency: an input change captured at edge k changes frame and id after edge k+1. Every level change counts (both rising and falling edges).
- Reset (rstn=0 at posedge):
  - s1 and s2 load the current clk_flash_anim, so no spurious tick follows reset.
  - f=0, hold_cnt=0, dir=up, state=RUN.
  - Outputs: id=BASE_ID, frame=0, busy=1, done=0.
- Accepted tick: tick & en & state==RUN & mode!=11. Ticks are dropped in every other case; the edge detector keeps tracking regardless.
- On an accepted tick:
  - If hold_cnt < HOLD-1: hold_cnt++.
  - Otherwise: hold_cnt=0 and the frame advances.
- Advance, loop mode: f = (f==N_FRAMES-1) ? 0 : f+1. dir is forced to up.
- Advance, ping-pong mode:
  - If dir=up: at N_FRAMES-1, dir=down and f=N_FRAMES-2; else f+1.
  - If dir=down: at 0, dir=up and f=1; else f-1.
  - No frame repeats at the ends.
- Advance, one-shot mode:
  - If f<N_FRAMES-1: f+1.
  - Else: state=FINISHED and done=1 for exactly one cycle; f stays at N_FRAMES-1.
- FINISHED state: id=NULL_ID, busy=0. Ticks and mode changes are ignored. Exit only via restart or reset.
- restart=1 at posedge: f=0, hold_cnt=0, dir=up, state=RUN, done=0. Restart has priority over a same-cycle tick, which is dropped. Restart during RUN behaves the same.
- Freeze mode (11) and en=0: f, hold_cnt and dir are held. Resuming continues with the remaining hold count.
- Mid-run mode change: takes effect at the next advance. A ping-pong run in dir=down that switches to loop goes up from the current f.
- Outputs in RUN: id = BASE_ID + f, computed at ID_W width with no wrap (guaranteed by the elaboration check). frame = f.
- done and busy are registered and glitch-free. id and frame are decoded from registers only.

Test Plan:
- Loop, default params: after reset, drive 9 level changes of clk_flash_anim ≥4 clk apart -> id sequence 4,5,6,7,4,5,6,7,4,5; each change reaches id 2 clk after the input edge.
- Ping-pong, N_FRAMES=4: drive 8 ticks -> id 4,5,6,7,6,5,4,5,6; no duplicated end frames.
- One-shot, HOLD=2: drive 8 ticks -> id 4,4,5,5,6,6,7,7; on tick 8, done pulses exactly one cycle, id=63, busy=0. Extra ticks leave id=63; restart gives id=4, busy=1.
- en=0 for 3 ticks mid-run at id=5, then en=1 -> id stays 5 during the gap, then resumes 6. The same holds with mode=11 in place of en=0.
- restart and tick asserted in the same cycle at id=6 -> id=4 and hold_cnt=0; the tick is not counted, and the next tick gives 5.
- rstn=0 asserted while clk_flash_anim=1, released, input held at 1 -> no tick and id=4. Reset pulsed mid-run at id=7 -> id=4 on the next cycle; done is never asserted.
